ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
- Frame-synchronous position controller for the on-screen ball/cursor sprite; sits between the button debouncers and the pixel compositor, driven by the pixel coordinates from vga_core.
- Detects end of active frame and runs a short update sequence, so sprite position changes only during blanking (no tearing).
- Two modes, toggled by center button:
  - MANUAL: buttons step the ball, clamped at screen edges.
  - BOUNCE: ball moves autonomously and reflects off edges; buttons steer direction.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BALL_SIZE, 10, sprite extent; sprite covers pos..pos+BALL_SIZE inclusive
STEP, 2, pixels moved per update (1..BALL_SIZE)
FRAME_DIV, 1, updates occur every FRAME_DIV frames (>=1)

Ports:
clk  in  1  pixel clock (25 MHz)
rst_n  in  1  reset; asynchronous assert, active-low
x_coord  in  16  current pixel x from vga_core
y_coord  in  16  current pixel y from vga_core
up  in  1  debounced level
down  in  1  debounced level
left  in  1  debounced level
right  in  1  debounced level
center  in  1  debounced level; rising edge toggles mode
x_pos  out  16  sprite top-left x
y_pos  out  16  sprite top-left y
mode  out  1  0=MANUAL, 1=BOUNCE
frame_tick  out  1  one-cycle pulse at detected end of frame
busy  out  1  high while update sequence is not IDLE

Behaviour:
- Constants:
  - X_MAX = H_ACTIVE-1-BALL_SIZE (629 default).
  - Y_MAX = V_ACTIVE-1-BALL_SIZE (469 default).
- Reset values (immediate on rst_n low, async):
  - x_pos = (H_ACTIVE-BALL_SIZE)/2 = 315; y_pos = (V_ACTIVE-BALL_SIZE)/2 = 235.
  - mode=0; vx=+ and vy=+ (internal direction bits).
  - frame counter=0; center edge flag=0.
  - state=IDLE; frame_tick=0; busy=0.
- End-of-frame detection:
  - eof condition: x_coord==H_ACTIVE-1 and y_coord==V_ACTIVE-1.
  - Registered rising edge of eof gives frame_tick, high for 1 cycle only, even if the condition holds longer.
- Frame divider:
  - Counter increments on each frame_tick and wraps at FRAME_DIV-1.
  - The update sequence starts on the frame_tick on which the counter equals FRAME_DIV-1.
- Center edge:
  - Rising edge of center sets a sticky flag at any time; the flag is consumed (cleared) in SAMPLE.
  - Multiple edges within one update period count as a single toggle.
- FSM, one cycle per state:
  - IDLE -> SAMPLE on qualified frame_tick.
  - SAMPLE: latch up/down/left/right levels; if flag set, toggle mode and clear flag. -> CALC_X.
  - CALC_X: compute next x into a shadow register. -> CALC_Y.
  - CALC_Y: compute next y into a shadow register. -> COMMIT.
  - COMMIT: copy shadows to x_pos/y_pos. -> IDLE.
  - busy is high in SAMPLE..COMMIT.
  - x_pos/y_pos change exactly 4 cycles after frame_tick, and never at any other time.
- MANUAL arithmetic, per axis:
  - left only: x = (x<STEP) ? 0 : x-STEP.
  - right only: x = min(x+STEP, X_MAX).
  - Both or neither: x unchanged. Y axis is identical with up/down and Y_MAX.
  - Compute in 17 bits; no wrap-around.
- BOUNCE arithmetic:
  - Steering first: left-only sets vx=-, right-only sets vx=+, up-only sets vy=-, down-only sets vy=+; both or neither keeps the current direction.
  - Move by STEP in the current direction.
  - Overshoot past X_MAX: x=X_MAX and vx=-. Past 0: x=0 and vx=+. Y axis is identical.
  - Landing exactly on a bound also flips direction.
- Mode toggle in SAMPLE takes effect in the same update's CALC states.
- Reset mid-sequence: outputs and FSM return to reset values; any partial shadow values are discarded.
- A frame_tick arriving while busy is ignored. This cannot happen with legal VGA timing.

Optional Feature:
- Macro: MOTION_WRAP_EN.
- Defined: in MANUAL mode, stepping past an edge wraps to the opposite bound instead of clamping.
  - x<STEP going left gives X_MAX; x+STEP>X_MAX going right gives 0. Y axis is identical.
  - BOUNCE mode is unaffected.
- Undefined: clamp behaviour as above; no wrap logic synthesized.

Test Plan:
- Reset with rst_n=0 mid-frame -> x_pos=315, y_pos=235, mode=0, busy=0 immediately. Release, then run 2 frames with no buttons -> position unchanged; frame_tick is a 1-cycle pulse per frame.
- MANUAL, right held -> x_pos 315->317 exactly 4 cycles after frame_tick; busy high for those 4 cycles. Up+down held -> y_pos stays 235.
- MANUAL clamp: drive to x=1, hold left -> x=0 next frame, then stays 0. At x=629 with right held -> stays 629. With MOTION_WRAP_EN: x=1, left -> 629; x=629, right -> 0.
- Center pulse -> mode=1 at the next update's SAMPLE. BOUNCE from x=627, vx=+ -> x=629 with vx=-, then 627, 625. Two center pulses in one frame -> single toggle.
- FRAME_DIV=3, right held -> x advances by 2 only on every 3rd frame_tick.
- Short-screen sim (H_ACTIVE=32, V_ACTIVE=24, BALL_SIZE=4) -> X_MAX=27, Y_MAX=19; BOUNCE corner hit flips vx and vy in the same update.

Source files
------------

// File: rtl/ball_motion_if.sv
// Signal bundle between the VGA raster/button side and ball_motion_ctrl.
// The slave modport is the controller's view; master is the driver's view.
interface ball_motion_if;
  logic [15:0] x_coord;
  logic [15:0] y_coord;
  logic        up;
  logic        down;
  logic        left;
  logic        right;
  logic        center;
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic        mode;
  logic        frame_tick;
  logic        busy;

  modport master (
    output x_coord, y_coord, up, down, left, right, center,
    input  x_pos, y_pos, mode, frame_tick, busy
  );

  modport slave (
    input  x_coord, y_coord, up, down, left, right, center,
    output x_pos, y_pos, mode, frame_tick, busy
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous sprite position controller: MANUAL stepping or autonomous BOUNCE.
// Define MOTION_WRAP_EN to make MANUAL stepping wrap at screen edges instead of clamping.
module ball_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 10,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input logic          clk,
  input logic          rst_n,
  ball_motion_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for a qualified frame_tick
  // SAMPLE | latch buttons, apply pending mode toggle
  // CALC_X | next x / vx into shadow
  // CALC_Y | next y / vy into shadow
  // COMMIT | shadows copied to x_pos / y_pos and direction bits
  typedef enum logic [2:0] {IDLE, SAMPLE, CALC_X, CALC_Y, COMMIT} state_t;

  localparam logic [16:0] X_MAX   = 17'(H_ACTIVE - 1 - BALL_SIZE);
  localparam logic [16:0] Y_MAX   = 17'(V_ACTIVE - 1 - BALL_SIZE);
  localparam logic [16:0] STEP_W  = 17'(STEP);
  localparam logic [15:0] STEP_16 = 16'(STEP);
  localparam logic [15:0] X_RST   = 16'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [15:0] Y_RST   = 16'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [15:0] X_EOF   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_EOF   = 16'(V_ACTIVE - 1);
  localparam int          DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  state_t           state, state_nx;
  logic             eof, eof_q, frame_tick_q;
  logic             center_q, center_rise, center_flag;
  logic [DIV_W-1:0] div_cnt;
  logic             tick_due, busy_c;
  logic             mode_q;
  logic [3:0]       btn_q;
  logic             vx, vy, sh_vx, sh_vy;
  logic [15:0]      x_q, y_q, sh_x, sh_y;
  logic [16:0]      nx, ny;

  // Returns {direction, position}; dir 1 = increasing coordinate.
  function automatic logic [16:0] axis_next(
    input logic [15:0] pos,
    input logic        dec,
    input logic        inc,
    input logic        dir,
    input logic        bounce,
    input logic [16:0] lim
  );
    logic [16:0] p, up_p;
    logic [15:0] np;
    logic        d;
    p    = {1'b0, pos};
    up_p = p + STEP_W;
    np   = pos;
    d    = dir;
    if (bounce) begin
      if (dec && !inc)      d = 1'b0;
      else if (inc && !dec) d = 1'b1;
      if (d) begin
        if (up_p >= lim) begin np = lim[15:0]; d = 1'b0; end
        else np = up_p[15:0];
      end else begin
        if (p <= STEP_W) begin np = '0; d = 1'b1; end
        else np = pos - STEP_16;
      end
    end else if (dec && !inc) begin
`ifdef MOTION_WRAP_EN
      if (p < STEP_W) np = lim[15:0];
`else
      if (p < STEP_W) np = '0;
`endif
      else np = pos - STEP_16;
    end else if (inc && !dec) begin
`ifdef MOTION_WRAP_EN
      if (up_p > lim) np = '0;
`else
      if (up_p > lim) np = lim[15:0];
`endif
      else np = up_p[15:0];
    end
    return {d, np};
  endfunction

  assign eof         = (bus.x_coord == X_EOF) && (bus.y_coord == Y_EOF);
  assign center_rise = bus.center && !center_q;
  assign tick_due    = frame_tick_q && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eof_q        <= 1'b0;
      frame_tick_q <= 1'b0;
      center_q     <= 1'b0;
      center_flag  <= 1'b0;
      div_cnt      <= '0;
    end else begin
      eof_q        <= eof;
      frame_tick_q <= eof && !eof_q;
      center_q     <= bus.center;
      if (frame_tick_q)
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      // An edge landing in SAMPLE itself is folded into this update's toggle.
      if (state == SAMPLE)  center_flag <= 1'b0;
      else if (center_rise) center_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_c   = 1'b1;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (tick_due) state_nx = SAMPLE;
      end
      SAMPLE:  state_nx = CALC_X;
      CALC_X:  state_nx = CALC_Y;
      CALC_Y:  state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign nx = axis_next(x_q, btn_q[1], btn_q[0], vx, mode_q, X_MAX);
  assign ny = axis_next(y_q, btn_q[3], btn_q[2], vy, mode_q, Y_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      btn_q  <= '0;
      vx     <= 1'b1;
      vy     <= 1'b1;
      sh_vx  <= 1'b1;
      sh_vy  <= 1'b1;
      x_q    <= X_RST;
      y_q    <= Y_RST;
      sh_x   <= X_RST;
      sh_y   <= Y_RST;
    end else begin
      unique case (state)
        SAMPLE: begin
          btn_q <= {bus.up, bus.down, bus.left, bus.right};
          if (center_flag || center_rise) mode_q <= ~mode_q;
        end
        CALC_X: {sh_vx, sh_x} <= nx;
        CALC_Y: {sh_vy, sh_y} <= ny;
        COMMIT: begin
          x_q <= sh_x;
          y_q <= sh_y;
          vx  <= sh_vx;
          vy  <= sh_vy;
        end
        default: ;
      endcase
    end
  end

  assign bus.x_pos      = x_q;
  assign bus.y_pos      = y_q;
  assign bus.mode       = mode_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: default-size instance plus a short-screen, FRAME_DIV=3 instance.
// Expected MANUAL edge results follow MOTION_WRAP_EN when it is defined for the build.
module tb_ball_motion_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  ball_motion_if bus();
  ball_motion_if s_bus();

  ball_motion_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  ball_motion_ctrl #(.H_ACTIVE(32), .V_ACTIVE(24), .BALL_SIZE(4), .STEP(2), .FRAME_DIV(3))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(s_bus));

  always #20 clk = ~clk;

  localparam logic [3:0] B_N = 4'b0000, B_U = 4'b1000, B_D = 4'b0100, B_L = 4'b0010, B_R = 4'b0001;

  typedef struct { logic [3:0] btn; int np; int ex; int ey; int em; } vec_t;
  typedef struct { int x; int y; int m; } exp_t;

  vec_t tbl[13];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_x, cur_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One update on the main instance: buttons, optional center pulses, end-of-frame, timing and result checks.
  task automatic upd(input logic [3:0] b, input int np, input int ex, input int ey, input int em);
    logic seen;
    exp_t e;
    @(negedge clk);
    {bus.up, bus.down, bus.left, bus.right} = b;
    for (int i = 0; i < np; i++) begin
      bus.center = 1'b1;
      @(negedge clk);
      bus.center = 1'b0;
      @(negedge clk);
    end
    exp_q.push_back('{ex, ey, em});
    bus.x_coord = 16'd639;
    bus.y_coord = 16'd479;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus.frame_tick;
    end
    chk("tick_seen", 32'(seen), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("tick_width", 32'(bus.frame_tick), 32'd0);
        bus.x_coord = 16'd0;
        bus.y_coord = 16'd0;
      end
      chk("busy_seq", 32'(bus.busy), 32'd1);
      chk("pos_hold", {bus.x_pos, bus.y_pos}, {16'(cur_x), 16'(cur_y)});
    end
    @(negedge clk);
    e = exp_q.pop_front();
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("x_pos", 32'(bus.x_pos), 32'(e.x));
    chk("y_pos", 32'(bus.y_pos), 32'(e.y));
    chk("mode", 32'(bus.mode), 32'(e.m));
    cur_x = e.x;
    cur_y = e.y;
  endtask

  task automatic s_tick();
    @(negedge clk);
    s_bus.x_coord = 16'd31;
    s_bus.y_coord = 16'd23;
    @(negedge clk);
    s_bus.x_coord = 16'd0;
    s_bus.y_coord = 16'd0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sx[6];
    int sy[6];
    logic seen;
    sx = '{20, 22, 24, 26, 27, 25};
    sy = '{12, 14, 16, 18, 19, 17};
    tbl[0]  = '{B_N,       0, 315, 235, 0};
    tbl[1]  = '{B_N,       0, 315, 235, 0};
    tbl[2]  = '{B_R,       0, 317, 235, 0};
    tbl[3]  = '{B_U | B_D, 0, 317, 235, 0};
    tbl[4]  = '{B_U,       0, 317, 233, 0};
    tbl[5]  = '{B_D | B_L, 0, 315, 235, 0};
    tbl[6]  = '{B_N,       1, 317, 237, 1};
    tbl[7]  = '{B_L,       0, 315, 239, 1};
    tbl[8]  = '{B_N,       0, 313, 241, 1};
    tbl[9]  = '{B_U,       0, 311, 239, 1};
    tbl[10] = '{B_R,       1, 313, 239, 0};
    tbl[11] = '{B_N,       2, 311, 237, 1};
    tbl[12] = '{B_N,       1, 311, 237, 0};

    rst_n = 1'b0;
    {bus.up, bus.down, bus.left, bus.right, bus.center} = 5'b0;
    {s_bus.up, s_bus.down, s_bus.left, s_bus.right, s_bus.center} = 5'b0;
    bus.x_coord = 16'd100;
    bus.y_coord = 16'd50;
    s_bus.x_coord = 16'd0;
    s_bus.y_coord = 16'd0;
    #30;
    chk("rst_x", 32'(bus.x_pos), 32'd315);
    chk("rst_y", 32'(bus.y_pos), 32'd235);
    chk("rst_mode", 32'(bus.mode), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);
    chk("s_rst_x", 32'(s_bus.x_pos), 32'd14);
    chk("s_rst_y", 32'(s_bus.y_pos), 32'd10);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur_x = 315;
    cur_y = 235;

    for (int i = 0; i < 13; i++) upd(tbl[i].btn, tbl[i].np, tbl[i].ex, tbl[i].ey, tbl[i].em);

    // Reset in the middle of an update sequence.
    @(negedge clk);
    bus.right = 1'b1;
    bus.x_coord = 16'd639;
    bus.y_coord = 16'd479;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus.frame_tick;
    end
    chk("mid_tick_seen", 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(bus.x_pos), 32'd315);
    chk("mid_rst_y", 32'(bus.y_pos), 32'd235);
    chk("mid_rst_mode", 32'(bus.mode), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    bus.x_coord = 16'd0;
    bus.y_coord = 16'd0;
    bus.right = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_x = 315;
    cur_y = 235;

    for (int k = 1; k <= 157; k++) upd(B_L, 0, 315 - 2 * k, 235, 0);
`ifdef MOTION_WRAP_EN
    upd(B_L, 0, 629, 235, 0);
    upd(B_R, 0, 0, 235, 0);
    upd(B_L, 0, 629, 235, 0);
    upd(B_L, 0, 627, 235, 0);
`else
    upd(B_L, 0, 0, 235, 0);
    upd(B_L, 0, 0, 235, 0);
    for (int k = 1; k <= 314; k++) upd(B_R, 0, 2 * k, 235, 0);
    upd(B_R, 0, 629, 235, 0);
    upd(B_R, 0, 629, 235, 0);
    upd(B_L, 0, 627, 235, 0);
`endif
    upd(B_R, 1, 629, 237, 1);
    upd(B_N, 0, 627, 239, 1);
    upd(B_N, 0, 625, 241, 1);

    // Short screen, FRAME_DIV=3: movement only on every third frame_tick.
    s_bus.right = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      s_tick();
      chk("div_x", 32'(s_bus.x_pos), 32'(14 + 2 * (t / 3)));
    end
    s_bus.right = 1'b0;
    @(negedge clk);
    s_bus.center = 1'b1;
    @(negedge clk);
    s_bus.center = 1'b0;
    for (int k = 0; k < 6; k++) begin
      repeat (3) s_tick();
      chk("s_bounce_x", 32'(s_bus.x_pos), 32'(sx[k]));
      chk("s_bounce_y", 32'(s_bus.y_pos), 32'(sy[k]));
    end
    chk("s_mode", 32'(s_bus.mode), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
